// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall controller: load-use scoreboard (EX/MEM) plus a mul/div occupancy FSM driving the StallBus.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_stall_ctrl #(
    parameter int unsigned MULDIV_LAT   = 4,
    parameter int unsigned LOAD_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic        id_we,
    input  logic [4:0]  id_waddr,
    input  logic        id_is_load,
    input  logic        id_is_muldiv,
    input  logic        ex_stallreq,
    output logic [5:0]  stall,
    output logic        muldiv_busy,
    output logic [31:0] perf_lu_cnt,
    output logic [31:0] perf_md_cnt
);

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t   state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic        ex_ld_v, mem_ld_v;
    logic [4:0]  ex_ld_addr, mem_ld_addr;
    logic        hit_ex, hit_mem, lu, md_hold;

    // $0 is excluded explicitly even though the scoreboard never records it.
    assign hit_ex  = id_valid & ex_ld_v & (ex_ld_addr != 5'd0) &
                     ((id_rs_used & (id_rs == ex_ld_addr)) | (id_rt_used & (id_rt == ex_ld_addr)));
    assign hit_mem = id_valid & mem_ld_v & (mem_ld_addr != 5'd0) &
                     ((id_rs_used & (id_rs == mem_ld_addr)) | (id_rt_used & (id_rt == mem_ld_addr)));
    assign lu      = hit_ex | ((LOAD_BUBBLES == 2) & hit_mem);
    assign md_hold = (state == BUSY) | ex_stallreq;

    assign muldiv_busy = (state == BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_ld_v     <= 1'b0;
            ex_ld_addr  <= '0;
            mem_ld_v    <= 1'b0;
            mem_ld_addr <= '0;
        end else begin
            if (!stall[2]) begin
                ex_ld_v    <= id_valid & id_is_load & id_we & (id_waddr != 5'd0);
                ex_ld_addr <= id_waddr;
            end else if (!stall[3]) begin
                ex_ld_v <= 1'b0;
            end

            if (!stall[3]) begin
                mem_ld_v    <= ex_ld_v;
                mem_ld_addr <= ex_ld_addr;
            end else if (!stall[4]) begin
                mem_ld_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = '0;

        if (md_hold) begin
            stall = 6'b001111;
        end else if (lu) begin
            stall = 6'b000111;
        end

        // Counts wall-clock cycles; external EX stalls do not pause it.
        case (state)
            IDLE: begin
                if ((MULDIV_LAT > 1) && !stall[2] && id_valid && id_is_muldiv) begin
                    state_nxt = BUSY;
                    cnt_nxt   = 6'(MULDIV_LAT - 1);
                end
            end
            BUSY: begin
                cnt_nxt = cnt - 6'd1;
                if (cnt == 6'd1) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] lu_cnt, md_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_cnt <= '0;
            md_cnt <= '0;
        end else if (md_hold) begin
            md_cnt <= md_cnt + 32'd1;
        end else if (lu) begin
            lu_cnt <= lu_cnt + 32'd1;
        end
    end

    assign perf_lu_cnt = lu_cnt;
    assign perf_md_cnt = md_cnt;
`else
    assign perf_lu_cnt = '0;
    assign perf_md_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: default instance plus LOAD_BUBBLES=2 and MULDIV_LAT=1 variants.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rs_used, id_rt_used, id_we, id_is_load, id_is_muldiv, ex_stallreq;
    logic [4:0]  id_rs, id_rt, id_waddr;
    logic [5:0]  stall, stall2, stall3;
    logic        busy, busy2, busy3;
    logic [31:0] plu, pmd, plu2, pmd2, plu3, pmd3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_we(id_we), .id_waddr(id_waddr),
        .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv), .ex_stallreq(ex_stallreq),
        .stall(stall), .muldiv_busy(busy), .perf_lu_cnt(plu), .perf_md_cnt(pmd)
    );

    hazard_stall_ctrl #(.LOAD_BUBBLES(2)) dut_lb2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_we(id_we), .id_waddr(id_waddr),
        .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv), .ex_stallreq(ex_stallreq),
        .stall(stall2), .muldiv_busy(busy2), .perf_lu_cnt(plu2), .perf_md_cnt(pmd2)
    );

    hazard_stall_ctrl #(.MULDIV_LAT(1)) dut_lat1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_we(id_we), .id_waddr(id_waddr),
        .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv), .ex_stallreq(ex_stallreq),
        .stall(stall3), .muldiv_busy(busy3), .perf_lu_cnt(plu3), .perf_md_cnt(pmd3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic rsu, input logic rtu, input logic we,
                          input logic [4:0] wa, input logic ld, input logic md);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_rs_used   = rsu;
        id_rt_used   = rtu;
        id_we        = we;
        id_waddr     = wa;
        id_is_load   = ld;
        id_is_muldiv = md;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic lw(input logic [4:0] rd);
        set_id(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b1, rd, 1'b1, 1'b0);
    endtask

    task automatic div_op();
        set_id(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_perf(input string tag, input logic [31:0] lu_exp, input logic [31:0] md_exp);
`ifdef HAZARD_PERF_EN
        chk({tag, "_lu"}, plu, lu_exp);
        chk({tag, "_md"}, pmd, md_exp);
`else
        chk({tag, "_lu"}, plu, 32'd0 & lu_exp);
        chk({tag, "_md"}, pmd, 32'd0 & md_exp);
`endif
    endtask

    initial begin
        rst = 1'b1;
        ex_stallreq = 1'b0;
        nop();
        #3;
        chk("rst_stall", 32'(stall), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_stall_lb2", 32'(stall2), 32'h00);
        chk_perf("rst_perf", 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // load-use: lw $2 then addu $3,$2,$4
        tick(); lw(5'd2); #1;
        chk("s1_lw", 32'(stall), 32'h00);
        tick(); set_id(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0); #1;
        chk("s1_lu", 32'(stall), 32'h07);
        chk("s1_lu_lb2", 32'(stall2), 32'h07);
        chk("s1_lu_lat1", 32'(stall3), 32'h07);
        tick(); #1;
        chk("s1_clear", 32'(stall), 32'h00);
        chk("s1_lu2_lb2", 32'(stall2), 32'h07);
        tick(); #1;
        chk("s1_done", 32'(stall), 32'h00);
        chk("s1_done_lb2", 32'(stall2), 32'h00);
        chk_perf("s1_perf", 32'd1, 32'd0);

        // $0 destination and unused source field never stall
        tick(); set_id(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0); #1;
        chk("s2_lw0", 32'(stall), 32'h00);
        tick(); set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0); #1;
        chk("s2_r0", 32'(stall), 32'h00);
        chk("s2_r0_lb2", 32'(stall2), 32'h00);
        tick(); lw(5'd5); #1;
        tick(); set_id(1'b1, 5'd5, 5'd6, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0); #1;
        chk("s2_unused", 32'(stall), 32'h00);
        chk("s2_unused_lb2", 32'(stall2), 32'h00);

        // div with MULDIV_LAT=4: three busy cycles
        tick(); div_op(); #1;
        chk("s3_pre", 32'(stall), 32'h00);
        for (int i = 0; i < 3; i++) begin
            tick(); nop(); #1;
            chk("s3_busy", 32'(busy), 32'h1);
            chk("s3_stall", 32'(stall), 32'h0f);
            chk("s3_lat1_busy", 32'(busy3), 32'h0);
            chk("s3_lat1_stall", 32'(stall3), 32'h00);
        end
        tick(); #1;
        chk("s3_exit_stall", 32'(stall), 32'h00);
        chk("s3_exit_busy", 32'(busy), 32'h0);
        chk_perf("s3_perf", 32'd1, 32'd3);

        // div in EX while lw $7 waits in ID, then a user of $7
        tick(); div_op(); #1;
        tick(); lw(5'd7); #1;
        chk("s4_b0", 32'(stall), 32'h0f);
        tick(); #1;
        chk("s4_b1", 32'(stall), 32'h0f);
        tick(); #1;
        chk("s4_b2", 32'(stall), 32'h0f);
        tick(); #1;
        chk("s4_exit", 32'(stall), 32'h00);
        tick(); set_id(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0); #1;
        chk("s4_lu", 32'(stall), 32'h07);
        tick(); #1;
        chk("s4_done", 32'(stall), 32'h00);
        chk_perf("s4_perf", 32'd2, 32'd6);

        // external stall outranks load-use and holds the scoreboard
        tick(); lw(5'd9); #1;
        tick(); set_id(1'b1, 5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0); ex_stallreq = 1'b1; #1;
        chk("s6_ext", 32'(stall), 32'h0f);
        chk("s6_ext_busy", 32'(busy), 32'h0);
        tick(); ex_stallreq = 1'b0; #1;
        chk("s6_lu", 32'(stall), 32'h07);
        tick(); #1;
        chk("s6_done", 32'(stall), 32'h00);

        // muldiv in ID blocked by load-use does not start the FSM
        tick(); lw(5'd10); #1;
        tick(); set_id(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1); #1;
        chk("s7_lu", 32'(stall), 32'h07);
        tick(); #1;
        chk("s7_nobusy", 32'(busy), 32'h0);
        chk("s7_nostall", 32'(stall), 32'h00);
        tick(); nop(); #1;
        chk("s7_busy", 32'(busy), 32'h1);
        tick(); #1;
        tick(); #1;
        chk("s7_busy_last", 32'(stall), 32'h0f);
        tick(); #1;
        chk("s7_exit", 32'(stall), 32'h00);
        chk_perf("s7_perf", 32'd4, 32'd10);

        // asynchronous reset in the middle of BUSY
        tick(); div_op(); #1;
        tick(); nop(); #1;
        tick(); #1;
        chk("s5_pre_busy", 32'(busy), 32'h1);
        rst = 1'b1; #1;
        chk("s5_rst_stall", 32'(stall), 32'h00);
        chk("s5_rst_busy", 32'(busy), 32'h0);
        chk_perf("s5_rst_perf", 32'd0, 32'd0);
        #1 rst = 1'b0; #1;
        chk("s5_rel_stall", 32'(stall), 32'h00);
        tick(); div_op(); #1;
        chk("s5_div_pre", 32'(stall), 32'h00);
        for (int i = 0; i < 3; i++) begin
            tick(); nop(); #1;
            chk("s5_busy", 32'(stall), 32'h0f);
        end
        tick(); #1;
        chk("s5_exit", 32'(stall), 32'h00);
        chk("s5_exit_busy", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
